// File: rtl/uart_pkg.sv
// Shared UART definitions.
// Holds the transmit-queue launch FSM state encoding and the default
// character/queue geometry used when UART blocks are instantiated.
package uart_pkg;

    // Default character width and log2 queue depth for UART blocks.
    localparam int UART_DATA_BITS  = 8;
    localparam int UART_FIFO_WIDTH = 4;

    // Launch FSM states of the transmit queue.
    typedef enum logic [1:0] {
        TX_Q_IDLE  = 2'd0,
        TX_Q_LOAD  = 2'd1,
        TX_Q_START = 2'd2,
        TX_Q_DRAIN = 2'd3
    } tx_q_state_t;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for signals crossing into the local clock domain.
// Ports:
//   clk - destination clock
//   rst - asynchronous active-high reset, clears both stages
//   d   - asynchronous input bus (bits synchronized independently)
//   q   - synchronized output, two clk edges behind d
module sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_r;
    logic [WIDTH-1:0] sync_r;

    // Two back-to-back capture stages; the first may go metastable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_r <= {WIDTH{1'b0}};
            sync_r <= {WIDTH{1'b0}};
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/tx_queue.sv
// UART transmit queue: circular character buffer feeding a launch FSM that
// hands one character at a time to the transmitter using a
// Transmit_Start / Tx_Busy handshake.
// Ports:
//   sys_clk        - single clock, all state on its rising edge
//   rst            - asynchronous active-high reset
//   push_data      - host write strobe, one character per high cycle
//   push_data_in   - host character
//   flush          - drop queued characters, clear tx_overflow
//   bist_mode      - blocks launching of new characters
//   tx_busy        - transmitter busy (asynchronous, synchronized here)
//   tx_data        - character presented to the transmitter
//   transmit_start - launch request, held until the transmitter is busy
//   tx_full        - queue holds DEPTH characters
//   tx_empty       - queue holds no characters
//   tx_overflow    - sticky: a push was rejected because the queue was full
//   tx_count       - number of queued characters (0..DEPTH)
module tx_queue
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = UART_DATA_BITS,
    parameter int FIFO_WIDTH = UART_FIFO_WIDTH
) (
    input  logic                  sys_clk,
    input  logic                  rst,
    input  logic                  push_data,
    input  logic [DATA_BITS-1:0]  push_data_in,
    input  logic                  flush,
    input  logic                  bist_mode,
    input  logic                  tx_busy,
    output logic [DATA_BITS-1:0]  tx_data,
    output logic                  transmit_start,
    output logic                  tx_full,
    output logic                  tx_empty,
    output logic                  tx_overflow,
    output logic [FIFO_WIDTH:0]   tx_count
);

    localparam int DEPTH = 2 ** FIFO_WIDTH;
    localparam logic [FIFO_WIDTH:0]   CNT_ZERO  = {(FIFO_WIDTH+1){1'b0}};
    localparam logic [FIFO_WIDTH:0]   CNT_ONE   = (FIFO_WIDTH+1)'(1);
    localparam logic [FIFO_WIDTH:0]   CNT_DEPTH = (FIFO_WIDTH+1)'(DEPTH);
    localparam logic [FIFO_WIDTH-1:0] PTR_ZERO  = {FIFO_WIDTH{1'b0}};
    localparam logic [FIFO_WIDTH-1:0] PTR_ONE   = FIFO_WIDTH'(1);
    localparam logic [DATA_BITS-1:0]  DATA_ZERO = {DATA_BITS{1'b0}};

    // Pointer advance; natural overflow wraps DEPTH-1 back to 0.
    function automatic logic [FIFO_WIDTH-1:0] ptr_inc(input logic [FIFO_WIDTH-1:0] p);
        return p + PTR_ONE;
    endfunction

    logic [DATA_BITS-1:0]  mem_r [DEPTH];
    logic [FIFO_WIDTH-1:0] wr_ptr_r;
    logic [FIFO_WIDTH-1:0] rd_ptr_r;
    logic [FIFO_WIDTH:0]   count_r;
    logic [DATA_BITS-1:0]  tx_data_r;
    logic                  start_r;
    logic                  overflow_r;
    tx_q_state_t           state_r;
    tx_q_state_t           state_nxt_s;
    logic                  busy_s;
    logic                  push_ok_s;
    logic                  pop_s;

    sync2 #(.WIDTH(1)) u_busy_sync (
        .clk (sys_clk),
        .rst (rst),
        .d   (tx_busy),
        .q   (busy_s)
    );

    assign tx_full  = (count_r == CNT_DEPTH);
    assign tx_empty = (count_r == CNT_ZERO);

    // A full queue rejects a push even when a pop happens in the same cycle;
    // a flush cycle also swallows any push.
    assign push_ok_s = push_data & ~tx_full & ~flush;
    assign pop_s     = (state_r == TX_Q_LOAD);

    // Buffer storage; deliberately not reset.
    always_ff @(posedge sys_clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data_in;
        end
    end

    // Pointers and occupancy; flush empties the queue in one cycle.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            count_r  <= CNT_ZERO;
        end else if (flush) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            count_r  <= CNT_ZERO;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({push_ok_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Sticky overflow flag, cleared only by reset or flush.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            overflow_r <= 1'b0;
        end else if (flush) begin
            overflow_r <= 1'b0;
        end else if (push_data && tx_full) begin
            overflow_r <= 1'b1;
        end
    end

    // Launch FSM next state. A flush cycle never starts a load, so LOAD
    // always finds at least one queued character.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            TX_Q_IDLE: begin
                if (!tx_empty && !bist_mode && !busy_s && !flush) begin
                    state_nxt_s = TX_Q_LOAD;
                end else begin
                    state_nxt_s = TX_Q_IDLE;
                end
            end
            TX_Q_LOAD: begin
                state_nxt_s = TX_Q_START;
            end
            TX_Q_START: begin
                if (busy_s) begin
                    state_nxt_s = TX_Q_DRAIN;
                end else begin
                    state_nxt_s = TX_Q_START;
                end
            end
            TX_Q_DRAIN: begin
                if (!busy_s) begin
                    state_nxt_s = TX_Q_IDLE;
                end else begin
                    state_nxt_s = TX_Q_DRAIN;
                end
            end
            default: begin
                state_nxt_s = TX_Q_IDLE;
            end
        endcase
    end

    // FSM state plus registered launch outputs. The head character is
    // captured on the LOAD edge and held until the next LOAD; flush does
    // not touch it, so an in-flight character always finishes.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_r   <= TX_Q_IDLE;
            tx_data_r <= DATA_ZERO;
            start_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            start_r <= (state_nxt_s == TX_Q_START);
            if (pop_s) begin
                tx_data_r <= mem_r[rd_ptr_r];
            end
        end
    end

    assign tx_data        = tx_data_r;
    assign transmit_start = start_r;
    assign tx_overflow    = overflow_r;
    assign tx_count       = count_r;

endmodule

// File: tb/tb_tx_queue.sv
// Directed self-checking bench for tx_queue (DATA_BITS=8, FIFO_WIDTH=4).
// Inputs are driven 1 ns after a rising edge, outputs sampled at that point.
module tb_tx_queue;

    logic       sys_clk;
    logic       rst;
    logic       push_data;
    logic [7:0] push_data_in;
    logic       flush;
    logic       bist_mode;
    logic       tx_busy;
    logic [7:0] tx_data;
    logic       transmit_start;
    logic       tx_full;
    logic       tx_empty;
    logic       tx_overflow;
    logic [4:0] tx_count;

    int total = 0;
    int bad   = 0;

    tx_queue #(.DATA_BITS(8), .FIFO_WIDTH(4)) dut (
        .sys_clk        (sys_clk),
        .rst            (rst),
        .push_data      (push_data),
        .push_data_in   (push_data_in),
        .flush          (flush),
        .bist_mode      (bist_mode),
        .tx_busy        (tx_busy),
        .tx_data        (tx_data),
        .transmit_start (transmit_start),
        .tx_full        (tx_full),
        .tx_empty       (tx_empty),
        .tx_overflow    (tx_overflow),
        .tx_count       (tx_count)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Step until transmit_start equals lvl or the budget runs out.
    task automatic wait_start(input logic lvl, input int max_steps, output int n);
        n = 0;
        while (transmit_start !== lvl && n <= max_steps) begin
            step();
            n++;
        end
    endtask

    task automatic push1(input logic [7:0] d);
        push_data    = 1'b1;
        push_data_in = d;
        step();
        push_data    = 1'b0;
    endtask

    initial begin
        int n;
        int starts;

        rst = 1'b1; push_data = 1'b0; push_data_in = 8'h00;
        flush = 1'b0; bist_mode = 1'b0; tx_busy = 1'b0;
        repeat (3) step();
        chk("rst_count", tx_count, 5'd0);
        chk("rst_empty", tx_empty, 1'b1);
        chk("rst_full", tx_full, 1'b0);
        chk("rst_start", transmit_start, 1'b0);
        chk("rst_data", tx_data, 8'h00);
        chk("rst_ovf", tx_overflow, 1'b0);
        rst = 1'b0;
        step();

        // Single character
        push1(8'hA5);
        wait_start(1'b1, 6, n);
        chk("single_start", transmit_start, 1'b1);
        chk("single_latency_le3", (n + 1) <= 3, 1'b1);
        chk("single_data", tx_data, 8'hA5);
        chk("single_count", tx_count, 5'd0);
        tx_busy = 1'b1;
        wait_start(1'b0, 6, n);
        chk("single_fall", transmit_start, 1'b0);
        chk("single_fall_2to3", (n >= 2) && (n <= 3), 1'b1);
        tx_busy = 1'b0;
        repeat (4) step();
        chk("single_empty", tx_empty, 1'b1);

        // Fill and overflow with the transmitter busy
        tx_busy = 1'b1;
        repeat (3) step();
        for (int i = 0; i < 16; i++) push1(8'(i));
        chk("fill_count", tx_count, 5'd16);
        chk("fill_full", tx_full, 1'b1);
        chk("fill_empty", tx_empty, 1'b0);
        chk("fill_ovf0", tx_overflow, 1'b0);
        chk("fill_nostart", transmit_start, 1'b0);
        push1(8'hEE);
        chk("ovf_flag", tx_overflow, 1'b1);
        chk("ovf_count", tx_count, 5'd16);

        // Drain in order through the handshake
        for (int i = 0; i < 16; i++) begin
            tx_busy = 1'b0;
            wait_start(1'b1, 12, n);
            chk("drain_start", transmit_start, 1'b1);
            chk("drain_data", tx_data, 8'(i));
            tx_busy = 1'b1;
            wait_start(1'b0, 6, n);
            chk("drain_fall", transmit_start, 1'b0);
        end
        tx_busy = 1'b0;
        repeat (8) step();
        chk("drain_empty", tx_empty, 1'b1);
        chk("drain_count", tx_count, 5'd0);
        chk("drain_nostart", transmit_start, 1'b0);
        chk("drain_ovf_sticky", tx_overflow, 1'b1);

        // Wrap-around: push exactly on each pop cycle at 15 occupancy
        tx_busy = 1'b1;
        repeat (3) step();
        for (int i = 0; i < 15; i++) push1(8'h40 + 8'(i));
        chk("wrap_fill", tx_count, 5'd15);
        for (int i = 0; i < 20; i++) begin
            tx_busy = 1'b0;
            // From IDLE the load cycle is 3 edges away, from DRAIN 4.
            repeat ((i == 0) ? 3 : 4) step();
            push1(8'h4F + 8'(i));
            chk("wrap_start", transmit_start, 1'b1);
            chk("wrap_data", tx_data, 8'h40 + 8'(i));
            chk("wrap_count", tx_count, 5'd15);
            tx_busy = 1'b1;
            wait_start(1'b0, 6, n);
            chk("wrap_fall", transmit_start, 1'b0);
        end

        // Flush mid-handshake
        chk("flush_ovf_before", tx_overflow, 1'b1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush1_count", tx_count, 5'd0);
        chk("flush1_ovf", tx_overflow, 1'b0);
        tx_busy = 1'b0;
        repeat (4) step();
        for (int k = 0; k < 6; k++) push1(8'h70 + 8'(k));
        chk("flush_pre_start", transmit_start, 1'b1);
        chk("flush_pre_data", tx_data, 8'h70);
        chk("flush_pre_count", tx_count, 5'd5);
        flush = 1'b1;
        push_data = 1'b1;
        push_data_in = 8'hBB;
        step();
        flush = 1'b0;
        push_data = 1'b0;
        chk("flush_count", tx_count, 5'd0);
        chk("flush_empty", tx_empty, 1'b1);
        chk("flush_inflight_start", transmit_start, 1'b1);
        chk("flush_inflight_data", tx_data, 8'h70);
        tx_busy = 1'b1;
        wait_start(1'b0, 6, n);
        chk("flush_fall", transmit_start, 1'b0);
        tx_busy = 1'b0;
        starts = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (transmit_start === 1'b1) starts++;
        end
        chk("flush_no_more_start", starts, 0);

        // Reset during DRAIN
        push1(8'h3C);
        wait_start(1'b1, 6, n);
        chk("rst6_start", transmit_start, 1'b1);
        chk("rst6_data", tx_data, 8'h3C);
        tx_busy = 1'b1;
        push1(8'h99);
        wait_start(1'b0, 6, n);
        chk("rst6_drain", transmit_start, 1'b0);
        chk("rst6_count1", tx_count, 5'd1);
        rst = 1'b1;
        #2;
        chk("async_rst_count", tx_count, 5'd0);
        chk("async_rst_data", tx_data, 8'h00);
        chk("async_rst_empty", tx_empty, 1'b1);
        chk("async_rst_full", tx_full, 1'b0);
        chk("async_rst_start", transmit_start, 1'b0);
        step();
        tx_busy = 1'b0;
        rst = 1'b0;
        step();
        push1(8'h5A);
        wait_start(1'b1, 6, n);
        chk("post_rst_start", transmit_start, 1'b1);
        chk("post_rst_data", tx_data, 8'h5A);
        tx_busy = 1'b1;
        wait_start(1'b0, 6, n);
        tx_busy = 1'b0;
        repeat (4) step();

        // BIST_Mode gates only the launch from IDLE
        bist_mode = 1'b1;
        push1(8'h11);
        starts = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (transmit_start === 1'b1) starts++;
        end
        chk("bist_block", starts, 0);
        chk("bist_count", tx_count, 5'd1);
        bist_mode = 1'b0;
        wait_start(1'b1, 6, n);
        chk("bist_release_data", tx_data, 8'h11);
        bist_mode = 1'b1;
        tx_busy = 1'b1;
        wait_start(1'b0, 6, n);
        chk("bist_complete", transmit_start, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
